// File: rtl/seq_pkg.sv
// Shared types for the 9-bit-ISA instruction sequencer: FSM state encoding,
// opcode field values and the default-width program-counter type.
package seq_pkg;

  localparam int PC_W_DEF = 10;

  typedef logic [PC_W_DEF-1:0] pc_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    DONE   = 3'd6
  } state_t;

  // Opcode field is Instr[8:6]
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_BNE = 3'b101;
  localparam logic [2:0] OP_LDR = 3'b110;
  localparam logic [2:0] OP_STR = 3'b111;

endpackage

// File: rtl/seq_pc.sv
// Program counter for the instruction sequencer: loads the run start address
// or a taken-branch target, otherwise steps by one (wrapping mod 2^PC_W).
module seq_pc #(
  parameter int PC_W       = 10,
  parameter int START_ADDR = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ld_start,
  input  logic            ld_br,
  input  logic            inc,
  input  logic [PC_W-1:0] br_target,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        pc <= PC_W'(START_ADDR);
    else if (ld_start) pc <= PC_W'(START_ADDR);
    else if (ld_br)    pc <= br_target;
    else if (inc)      pc <= pc + PC_W'(1);
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 9-bit-ISA core.
// Optional perf counters (CycCnt/InsCnt) are built when SEQ_PERF_CNT_EN is defined.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W       = 10,
  parameter int START_ADDR = 0,
  parameter int MEM_TMO    = 255
`ifdef SEQ_PERF_CNT_EN
  ,
  parameter int CNT_W      = 32
`endif
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            Start,
  input  logic [PC_W-1:0] ProgEnd,
  input  logic [8:0]      Instr,
  input  logic            DecBranch,
  input  logic            DecMemWrite,
  input  logic            DecMemtoReg,
  input  logic            DecRegWrite,
  input  logic            BrTaken,
  input  logic [PC_W-1:0] BrTarget,
  input  logic            MemRdy,
  output logic [PC_W-1:0] PC,
  output logic [8:0]      IR,
  output logic            RegWrEn,
  output logic            MemReq,
  output logic            MemWrEn,
  output logic            Ack,
  output logic            Err
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] CycCnt,
  output logic [CNT_W-1:0] InsCnt
`endif
);

  state_t     state, nstate;
  logic [7:0] wcnt;
  logic       mem_tmo;
  logic       ld_start, ld_br, inc;

  seq_pc #(
    .PC_W       (PC_W),
    .START_ADDR (START_ADDR)
  ) u_pc (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .ld_start  (ld_start),
    .ld_br     (ld_br),
    .inc       (inc),
    .br_target (BrTarget),
    .pc        (PC)
  );

  // A ready strobe on the last allowed wait cycle still wins over the abort
  assign mem_tmo = (state == MEM) && !MemRdy && (wcnt == 8'(MEM_TMO - 1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      IR    <= '0;
      Err   <= 1'b0;
      wcnt  <= '0;
    end else begin
      state <= nstate;
      if (state == DECODE) IR <= Instr;
      if (state == IDLE && Start) Err <= 1'b0;
      else if (mem_tmo)           Err <= 1'b1;
      if (state == MEM) wcnt <= wcnt + 8'd1;
      else              wcnt <= '0;
    end
  end

  always_comb begin
    nstate   = state;
    RegWrEn  = 1'b0;
    MemReq   = 1'b0;
    MemWrEn  = 1'b0;
    Ack      = 1'b0;
    ld_start = 1'b0;
    ld_br    = 1'b0;
    inc      = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          nstate   = FETCH;
          ld_start = 1'b1;
        end
      end
      FETCH:  nstate = (PC == ProgEnd) ? DONE : DECODE;
      DECODE: nstate = EXEC;
      EXEC:   nstate = (DecMemWrite || DecMemtoReg) ? MEM : WB;
      MEM: begin
        MemReq  = 1'b1;
        MemWrEn = DecMemWrite;
        if (MemRdy)       nstate = WB;
        else if (mem_tmo) nstate = DONE;
      end
      WB: begin
        RegWrEn = DecRegWrite;
        if (DecBranch && BrTaken) ld_br = 1'b1;
        else                      inc   = 1'b1;
        nstate = FETCH;
      end
      DONE: begin
        Ack = 1'b1;
        if (!Start) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

`ifdef SEQ_PERF_CNT_EN
  // Counters saturate rather than wrap so a long run never reads as a short one
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      CycCnt <= '0;
      InsCnt <= '0;
    end else if (state == IDLE) begin
      if (Start) begin
        CycCnt <= '0;
        InsCnt <= '0;
      end
    end else if (state != DONE) begin
      if (CycCnt != '1)                   CycCnt <= CycCnt + CNT_W'(1);
      if (state == WB && InsCnt != '1)    InsCnt <= InsCnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a cycle model queues per-cycle stimulus
// and expected outputs for each run; the queue is drained one entry per clock.
module tb_instr_sequencer;
  import seq_pkg::*;

  localparam int PC_W = 10;
  localparam int TMO  = 255;

  logic            Clk = 1'b0;
  logic            Reset_n, Start, BrTaken, MemRdy;
  logic            DecBranch, DecMemWrite, DecMemtoReg, DecRegWrite;
  logic [PC_W-1:0] ProgEnd, BrTarget, PC;
  logic [8:0]      Instr, IR;
  logic            RegWrEn, MemReq, MemWrEn, Ack, Err;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0]     CycCnt, InsCnt;
`endif

  logic [8:0] rom [0:(1<<PC_W)-1];

  assign Instr       = rom[PC];
  assign DecBranch   = (IR[8:6] == OP_BNE);
  assign DecMemWrite = (IR[8:6] == OP_STR);
  assign DecMemtoReg = (IR[8:6] == OP_LDR);
  assign DecRegWrite = (IR[8:6] inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_LDR});

  instr_sequencer #(.PC_W(PC_W), .START_ADDR(0), .MEM_TMO(TMO)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .ProgEnd(ProgEnd), .Instr(Instr),
    .DecBranch(DecBranch), .DecMemWrite(DecMemWrite), .DecMemtoReg(DecMemtoReg),
    .DecRegWrite(DecRegWrite), .BrTaken(BrTaken), .BrTarget(BrTarget), .MemRdy(MemRdy),
    .PC(PC), .IR(IR), .RegWrEn(RegWrEn), .MemReq(MemReq), .MemWrEn(MemWrEn),
    .Ack(Ack), .Err(Err)
`ifdef SEQ_PERF_CNT_EN
    , .CycCnt(CycCnt), .InsCnt(InsCnt)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       start, taken, rdy;
    logic       regwr, memreq, memwr, ack, err;
    logic [9:0] pc;
    logic [8:0] ir;
  } exp_t;

  exp_t sbq[$];
  bit   taken_plan[$];
  int   n_chk = 0, n_pass = 0;
  logic [8:0] m_ir;
  logic       m_err;
  int         m_cyc, m_ins;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic void push(input logic st, input logic tk, input logic rd,
                               input logic rw, input logic mq, input logic mw,
                               input logic ak, input logic er, input logic [9:0] pc);
    exp_t e;
    e.start = st; e.taken = tk; e.rdy = rd;
    e.regwr = rw; e.memreq = mq; e.memwr = mw; e.ack = ak; e.err = er;
    e.pc = pc; e.ir = m_ir;
    sbq.push_back(e);
  endfunction

  // Cycle model of one run; lat = MEM cycle on which MemRdy fires (0 = never)
  task automatic build(input logic [9:0] pend, input int lat, input logic [9:0] tgt);
    logic [9:0] pc = 10'd0;
    logic [2:0] op;
    logic       tk, rd, rw, tmo;
    m_err = 1'b0; m_cyc = 0; m_ins = 0;
    for (int step = 0; step < 200; step++) begin
      push(1'($urandom_range(0, 1)), 0, 0, 0, 0, 0, 0, 0, pc); m_cyc++;
      if (pc == pend) break;
      push(1'($urandom_range(0, 1)), 0, 0, 0, 0, 0, 0, 0, pc); m_cyc++;
      m_ir = rom[pc];
      push(1'($urandom_range(0, 1)), 0, 0, 0, 0, 0, 0, 0, pc); m_cyc++;
      op  = m_ir[8:6];
      rw  = (op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_LDR});
      tmo = 1'b0;
      if (op == OP_LDR || op == OP_STR) begin
        for (int k = 1; k <= TMO; k++) begin
          rd = (lat != 0) && (k == lat);
          push(1'($urandom_range(0, 1)), 0, rd, 0, 1, (op == OP_STR), 0, 0, pc); m_cyc++;
          if (rd) break;
          if (k == TMO) tmo = 1'b1;
        end
      end
      if (tmo) begin
        m_err = 1'b1;
        break;
      end
      tk = 1'b0;
      if (op == OP_BNE && taken_plan.size() > 0) tk = taken_plan.pop_front();
      push(1'($urandom_range(0, 1)), tk, 0, rw, 0, 0, 0, 0, pc); m_cyc++; m_ins++;
      pc = tk ? tgt : pc + 10'd1;
    end
    push(1, 0, 0, 0, 0, 0, 1, m_err, pc);
    push(0, 0, 0, 0, 0, 0, 1, m_err, pc);
    push(0, 0, 0, 0, 0, 0, 0, m_err, pc);
  endtask

  task automatic run(input string name, input logic [9:0] pend, input int lat,
                     input logic [9:0] tgt);
    exp_t e;
    int   cyc = 0;
    ProgEnd  = pend;
    BrTarget = tgt;
    build(pend, lat, tgt);
    @(negedge Clk);
    Start = 1'b1; BrTaken = 1'b0; MemRdy = 1'b0;
    while (sbq.size() > 0) begin
      @(negedge Clk);
      e = sbq.pop_front();
      Start = e.start; BrTaken = e.taken; MemRdy = e.rdy;
      chk($sformatf("%s c%0d RegWrEn", name, cyc), 32'(RegWrEn), 32'(e.regwr));
      chk($sformatf("%s c%0d MemReq", name, cyc),  32'(MemReq),  32'(e.memreq));
      chk($sformatf("%s c%0d MemWrEn", name, cyc), 32'(MemWrEn), 32'(e.memwr));
      chk($sformatf("%s c%0d Ack", name, cyc),     32'(Ack),     32'(e.ack));
      chk($sformatf("%s c%0d Err", name, cyc),     32'(Err),     32'(e.err));
      chk($sformatf("%s c%0d PC", name, cyc),      32'(PC),      32'(e.pc));
      chk($sformatf("%s c%0d IR", name, cyc),      32'(IR),      32'(e.ir));
      cyc++;
    end
`ifdef SEQ_PERF_CNT_EN
    chk($sformatf("%s CycCnt", name), CycCnt, 32'(m_cyc));
    chk($sformatf("%s InsCnt", name), InsCnt, 32'(m_ins));
`endif
  endtask

  initial begin
    bit seen;
    Reset_n = 1'b0; Start = 1'b0; BrTaken = 1'b0; MemRdy = 1'b0;
    ProgEnd = '0; BrTarget = '0;
    for (int i = 0; i < (1 << PC_W); i++) rom[i] = {OP_ADD, 6'd0};
    m_ir = '0; m_err = 1'b0;
    #12;
    chk("rst PC", 32'(PC), 0);
    chk("rst IR", 32'(IR), 0);
    chk("rst strobes", {RegWrEn, MemReq, MemWrEn, Ack, Err}, 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    rom[0] = 9'h081; rom[1] = 9'h0C2; rom[2] = 9'h003;
    run("alu3", 10'd3, 0, 10'd0);
    run("empty", 10'd0, 0, 10'd0);

    rom[0] = {OP_LDR, 6'd5};
    run("load", 10'd1, 3, 10'd0);
    rom[0] = {OP_STR, 6'd3};
    run("store", 10'd1, 2, 10'd0);
    rom[0] = {OP_LDR, 6'd1}; rom[1] = {OP_STR, 6'd2}; rom[2] = {OP_SLT, 6'd7};
    run("ldst1", 10'd3, 1, 10'd0);

    for (int i = 0; i < 5; i++) rom[i] = {OP_ADD, 6'(i)};
    rom[5] = {OP_BNE, 6'd9};
    taken_plan = '{1'b1, 1'b0};
    run("bne", 10'd6, 0, 10'd2);

    rom[0] = {OP_BNE, 6'd1}; rom[1023] = {OP_OR, 6'd4};
    taken_plan = '{1'b1, 1'b0};
    run("wrap", 10'd1, 0, 10'd1023);

    rom[0] = {OP_LDR, 6'd6};
    run("tmo", 10'd1, 0, 10'd0);
    run("errclr", 10'd0, 0, 10'd0);

    // Asynchronous reset while a load at PC=1 waits in MEM
    rom[0] = {OP_ADD, 6'd1}; rom[1] = {OP_LDR, 6'd2};
    ProgEnd = 10'd2;
    @(negedge Clk);
    Start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge Clk);
      seen = MemReq && (PC == 10'd1);
    end
    chk("rst-mem reached MEM", 32'(seen), 1);
    #2 Reset_n = 1'b0;
    #1;
    chk("rst-mem MemReq", 32'(MemReq), 0);
    chk("rst-mem PC", 32'(PC), 0);
    chk("rst-mem IR", 32'(IR), 0);
    chk("rst-mem Ack", 32'(Ack), 0);
    Start = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      chk($sformatf("post-rst c%0d strobes", i), {RegWrEn, MemReq, Ack, Err}, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
